// File: rtl/enqueue_admission.sv
// enqueue_admission: tracks per-queue buffer occupancy and admits or drops
// enqueue requests against private thresholds and a shared buffer pool.
module enqueue_admission #(
  parameter int                    NUM_QUEUES  = 8,
  parameter int                    QID_W       = 3,
  parameter int                    LEN_W       = 11,
  parameter int                    CNT_W       = 12,
  parameter logic [NUM_QUEUES-1:0] CYCLIC_MASK = 8'b1100_0000,
  parameter int                    THR_MIN     = 52,
  parameter int                    THR_MAX     = 330,
  parameter int                    SHARED_SIZE = 512
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [QID_W-1:0] req_qid,
  input  logic [LEN_W-1:0] req_len,
  input  logic             deq_valid,
  output logic             deq_ready,
  input  logic [QID_W-1:0] deq_qid,
  input  logic [LEN_W-1:0] deq_len,
  output logic             res_valid,
  output logic             res_accept,
  output logic [QID_W-1:0] res_qid,
  output logic [CNT_W-1:0] res_occ,
  output logic [CNT_W-1:0] shared_free,
  output logic [15:0]      drop_cnt,
  output logic             err_underflow
);

  // All occupancy arithmetic is one bit wider than the counters so that
  // sums and differences never wrap before they are compared.
  typedef logic [CNT_W:0] wide_t;

  localparam wide_t THR_MIN_W = wide_t'(THR_MIN);
  localparam wide_t THR_MAX_W = wide_t'(THR_MAX);

  typedef enum logic [1:0] {IDLE, JUDGE, COMMIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] occ_reg [NUM_QUEUES];
  logic [CNT_W-1:0] shared_used_reg;
  logic [15:0]      drop_cnt_reg;
  logic             err_reg;
  logic [QID_W-1:0] qid_reg;
  logic [LEN_W-1:0] len_reg;
  logic             accept_reg;
  logic [CNT_W-1:0] need_reg;
  logic [CNT_W-1:0] new_reg;
  logic             res_valid_reg;
  logic             res_accept_reg;
  logic [QID_W-1:0] res_qid_reg;
  logic [CNT_W-1:0] res_occ_reg;

  logic             cyclic [NUM_QUEUES];
  logic [CNT_W-1:0] free_c;
  wide_t            free_w;

  wide_t            rel_old, rel_len, rel_new, rel_dec;
  logic             rel_under;
  logic [CNT_W-1:0] rel_used;

  wide_t            jdg_old, jdg_len, jdg_new, jdg_need;
  logic             jdg_accept;

  function automatic wide_t sat(input wide_t x);
    return (x > THR_MIN_W) ? x - THR_MIN_W : '0;
  endfunction

  for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_class
    assign cyclic[gi] = CYCLIC_MASK[gi];
  end

  assign free_c = CNT_W'(SHARED_SIZE) - shared_used_reg;
  assign free_w = {1'b0, free_c};

  // Release path: clamp at zero and return only the pool units the queue held.
  always_comb begin
    rel_old   = {1'b0, occ_reg[deq_qid]};
    rel_len   = wide_t'(deq_len);
    rel_under = rel_len > rel_old;
    rel_new   = rel_under ? '0 : rel_old - rel_len;
    rel_dec   = cyclic[deq_qid] ? rel_old - rel_new : sat(rel_old) - sat(rel_new);
    rel_used  = (rel_dec > {1'b0, shared_used_reg}) ? '0
              : CNT_W'({1'b0, shared_used_reg} - rel_dec);
  end

  // Admission decision for the latched request.
  always_comb begin
    jdg_old    = {1'b0, occ_reg[qid_reg]};
    jdg_len    = wide_t'(len_reg);
    jdg_new    = jdg_old + jdg_len;
    jdg_need   = jdg_len;
    jdg_accept = 1'b0;
    if (cyclic[qid_reg]) begin
      jdg_accept = jdg_len < free_w;
    end else begin
      jdg_need   = sat(jdg_new) - sat(jdg_old);
      jdg_accept = (jdg_new <= THR_MAX_W) && (jdg_need <= free_w);
    end
    if (jdg_new[CNT_W]) begin
      jdg_accept = 1'b0;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    deq_ready  = 1'b0;
    case (state_reg)
      IDLE: begin
        deq_ready = 1'b1;
        req_ready = !deq_valid;
        if (!deq_valid && req_valid) begin
          state_next = JUDGE;
        end
      end
      JUDGE:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_reg       <= IDLE;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        occ_reg[i] <= '0;
      end
      shared_used_reg <= '0;
      drop_cnt_reg    <= '0;
      err_reg         <= 1'b0;
      qid_reg         <= '0;
      len_reg         <= '0;
      accept_reg      <= 1'b0;
      need_reg        <= '0;
      new_reg         <= '0;
      res_valid_reg   <= 1'b0;
      res_accept_reg  <= 1'b0;
      res_qid_reg     <= '0;
      res_occ_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      res_valid_reg <= 1'b0;

      if (state_reg == IDLE) begin
        if (deq_valid) begin
          occ_reg[deq_qid] <= rel_new[CNT_W-1:0];
          shared_used_reg  <= rel_used;
          if (rel_under) begin
            err_reg <= 1'b1;
          end
        end else if (req_valid) begin
          qid_reg <= req_qid;
          len_reg <= req_len;
        end
      end

      if (state_reg == JUDGE) begin
        accept_reg     <= jdg_accept;
        need_reg       <= jdg_need[CNT_W-1:0];
        new_reg        <= jdg_new[CNT_W-1:0];
        res_valid_reg  <= 1'b1;
        res_accept_reg <= jdg_accept;
        res_qid_reg    <= qid_reg;
        res_occ_reg    <= jdg_accept ? jdg_new[CNT_W-1:0] : jdg_old[CNT_W-1:0];
      end

      // Counters only move here, one cycle after the decision is shown.
      if (state_reg == COMMIT) begin
        if (accept_reg) begin
          occ_reg[qid_reg] <= new_reg;
          shared_used_reg  <= shared_used_reg + need_reg;
        end else if (drop_cnt_reg != 16'hFFFF) begin
          drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign res_valid     = res_valid_reg;
  assign res_accept    = res_accept_reg;
  assign res_qid       = res_qid_reg;
  assign res_occ       = res_occ_reg;
  assign shared_free   = free_c;
  assign drop_cnt      = drop_cnt_reg;
  assign err_underflow = err_reg;

endmodule

// File: tb/tb_enqueue_admission.sv
// Bench for enqueue_admission: directed steps then random traffic, each
// result compared against a queue-level occupancy/pool model.
module tb_enqueue_admission;

  localparam int        NQ      = 8;
  localparam logic [7:0] CYC    = 8'b1100_0000;
  localparam int        TMIN    = 52;
  localparam int        TMAX    = 330;
  localparam int        SHARED  = 512;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_qid;
  logic [10:0] req_len;
  logic        deq_valid;
  logic        deq_ready;
  logic [2:0]  deq_qid;
  logic [10:0] deq_len;
  logic        res_valid;
  logic        res_accept;
  logic [2:0]  res_qid;
  logic [11:0] res_occ;
  logic [11:0] shared_free;
  logic [15:0] drop_cnt;
  logic        err_underflow;

  int n_cmp = 0;
  int n_mis = 0;

  int occ_m [NQ];
  int used_m;
  int drop_m;
  int err_m;

  enqueue_admission dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_qid       (req_qid),
    .req_len       (req_len),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_qid       (deq_qid),
    .deq_len       (deq_len),
    .res_valid     (res_valid),
    .res_accept    (res_accept),
    .res_qid       (res_qid),
    .res_occ       (res_occ),
    .shared_free   (shared_free),
    .drop_cnt      (drop_cnt),
    .err_underflow (err_underflow)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int satf(input int x);
    return (x > TMIN) ? x - TMIN : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NQ; i++) occ_m[i] = 0;
    used_m = 0;
    drop_m = 0;
    err_m  = 0;
  endtask

  task automatic model_release(input int q, input int len);
    int old_v, new_v;
    old_v = occ_m[q];
    new_v = (len > old_v) ? 0 : old_v - len;
    if (len > old_v) err_m = 1;
    if (CYC[q]) used_m -= (old_v - new_v);
    else        used_m -= (satf(old_v) - satf(new_v));
    occ_m[q] = new_v;
  endtask

  task automatic model_judge(input int q, input int len, output int acc, output int occ_after);
    int old_v, new_v, need, free_v;
    old_v  = occ_m[q];
    new_v  = old_v + len;
    free_v = SHARED - used_m;
    if (CYC[q]) begin
      need = len;
      acc  = (len < free_v) ? 1 : 0;
    end else begin
      need = satf(new_v) - satf(old_v);
      acc  = (new_v <= TMAX && need <= free_v) ? 1 : 0;
    end
    if (acc == 1) begin
      occ_m[q] = new_v;
      used_m  += need;
    end else if (drop_m != 65535) begin
      drop_m++;
    end
    occ_after = occ_m[q];
  endtask

  // Called just after a rising edge with the block in IDLE.
  task automatic transact(input bit dv, input int dq, input int dl,
                          input bit rv, input int rq, input int rl);
    int acc, occ_after, waited;
    acc = 0;
    occ_after = 0;
    deq_valid = dv;
    deq_qid   = 3'(dq);
    deq_len   = 11'(dl);
    req_valid = rv;
    req_qid   = 3'(rq);
    req_len   = 11'(rl);
    #1;
    if (dv) begin
      check("deq_ready", 32'(deq_ready), 1);
      check("req_ready_blocked", 32'(req_ready), 0);
      @(posedge clk_in); #1;
      deq_valid = 1'b0;
      model_release(dq, dl);
      check("rel_shared_free", 32'(shared_free), SHARED - used_m);
      check("rel_err_underflow", 32'(err_underflow), err_m);
      #1;
    end
    if (rv) begin
      waited = 0;
      while (req_ready !== 1'b1 && waited < 8) begin
        @(posedge clk_in); #2;
        waited++;
      end
      check("req_handshake", 32'(req_ready), 1);
      @(posedge clk_in); #1;
      req_valid = 1'b0;
      check("judge_res_valid", 32'(res_valid), 0);
      check("judge_req_ready", 32'(req_ready), 0);
      @(posedge clk_in); #1;
      model_judge(rq, rl, acc, occ_after);
      check("res_valid", 32'(res_valid), 1);
      check("res_accept", 32'(res_accept), acc);
      check("res_qid", 32'(res_qid), rq);
      check("res_occ", 32'(res_occ), occ_after);
      check("commit_req_ready", 32'(req_ready), 0);
      @(posedge clk_in); #1;
      check("post_res_valid", 32'(res_valid), 0);
      check("post_shared_free", 32'(shared_free), SHARED - used_m);
      check("post_drop_cnt", 32'(drop_cnt), drop_m);
      check("post_req_ready", 32'(req_ready), 1);
    end
    $display("txn deq=%0d q%0d len%0d | req=%0d q%0d len%0d acc=%0d occ=%0d | free=%0d drops=%0d",
             dv, dq, dl, rv, rq, rl, acc, occ_after, SHARED - used_m, drop_m);
  endtask

  initial begin
    int op, q1, q2, l1, l2;
    rst = 1'b1;
    req_valid = 1'b0; req_qid = '0; req_len = '0;
    deq_valid = 1'b0; deq_qid = '0; deq_len = '0;
    model_reset();

    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;
    #1;
    check("rst_shared_free", 32'(shared_free), 512);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_deq_ready", 32'(deq_ready), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_occ", 32'(res_occ), 0);
    check("rst_err", 32'(err_underflow), 0);

    // Reset while a decision is in flight.
    @(posedge clk_in); #1;
    req_valid = 1'b1; req_qid = 3'd3; req_len = 11'd100;
    #1;
    check("rj_handshake", 32'(req_ready), 1);
    @(posedge clk_in); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk_in); #1;
    rst = 1'b0;
    check("rj_res_valid_a", 32'(res_valid), 0);
    @(posedge clk_in); #1;
    check("rj_res_valid_b", 32'(res_valid), 0);
    check("rj_shared_free", 32'(shared_free), 512);
    check("rj_req_ready", 32'(req_ready), 1);
    model_reset();

    transact(0, 0, 0, 1, 0, 40);
    check("p_fill1_occ", 32'(res_occ), 40);
    check("p_fill1_free", 32'(shared_free), 512);
    transact(0, 0, 0, 1, 0, 20);
    check("p_fill2_occ", 32'(res_occ), 60);
    check("p_fill2_free", 32'(shared_free), 504);
    transact(0, 0, 0, 1, 0, 271);
    check("p_max_rej", 32'(res_accept), 0);
    check("p_max_rej_occ", 32'(res_occ), 60);
    check("p_max_drop", 32'(drop_cnt), 1);
    transact(0, 0, 0, 1, 0, 270);
    check("p_max_acc", 32'(res_accept), 1);
    check("p_max_free", 32'(shared_free), 234);
    transact(0, 0, 0, 1, 7, 234);
    check("p_cyc_rej", 32'(res_accept), 0);
    transact(0, 0, 0, 1, 7, 233);
    check("p_cyc_acc", 32'(res_accept), 1);
    check("p_cyc_occ", 32'(res_occ), 233);
    check("p_cyc_free", 32'(shared_free), 1);
    transact(1, 0, 330, 1, 1, 10);
    check("p_prio_occ", 32'(res_occ), 10);
    check("p_prio_free", 32'(shared_free), 279);
    transact(1, 2, 5, 0, 0, 0);
    check("p_under_err", 32'(err_underflow), 1);
    @(posedge clk_in); #1;
    check("p_under_sticky", 32'(err_underflow), 1);

    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 3));
      q1 = int'($urandom_range(0, NQ - 1));
      q2 = int'($urandom_range(0, NQ - 1));
      l1 = int'($urandom_range(0, occ_m[q1] + 8));
      l2 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 400))
                                       : int'($urandom_range(0, 80));
      case (op)
        2:       transact(1, q1, l1, 0, 0, 0);
        3:       transact(1, q1, l1, 1, q2, l2);
        default: transact(0, 0, 0, 1, q2, l2);
      endcase
    end

    // Preload the drop counter near its ceiling rather than issuing 65k rejects.
    force dut.drop_cnt_reg = 16'hFFFD;
    #1;
    release dut.drop_cnt_reg;
    drop_m = 65533;
    for (int i = 0; i < 3; i++) begin
      transact(0, 0, 0, 1, 0, 2000);
    end
    check("drop_saturated", 32'(drop_cnt), 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
